// File: rtl/i2c_bus_sequencer_if.sv
// Bus bundle between the address translator FSM and the bit-level I2C sequencer.
//   master: translator side / pad environment (issues commands, supplies raw pin levels)
//   slave : sequencer side (accepts commands, drives open-drain enables and responses)
// Signals:
//   cmd_valid, cmd_ready, cmd[1:0], cmd_bit      command handshake
//   rsp_valid, rsp_bit, rsp_err, busy            completion / bus-ownership status
//   scl_oe, sda_oe                               1 = pull the line low
//   scl_in, sda_in                               raw asynchronous pin levels
interface i2c_bus_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_bit;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       rsp_err;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;

  modport master (
    output cmd_valid, cmd, cmd_bit, scl_in, sda_in,
    input  cmd_ready, rsp_valid, rsp_bit, rsp_err, busy, scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bit, scl_in, sda_in,
    output cmd_ready, rsp_valid, rsp_bit, rsp_err, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_bus_sequencer.sv
// Bit-level I2C bus sequencer. Executes one command (START, STOP, WRITE bit, READ bit) at a
// time as four quarter-period phases of CLK_DIV ref_clk cycles each, driving open-drain
// enables for SCL/SDA and returning the SDA bit sampled at the end of phase 1.
// Ports:
//   ref_clk  system clock (rising edge)
//   reset    asynchronous active-low reset; aborts any command and releases both lines
//   bus      i2c_bus_sequencer_if.slave (command handshake, response, enables, raw pins)
// Parameters:
//   CLK_DIV  ref_clk cycles per quarter SCL period (4..1023)
// Configuration macro:
//   I2C_CLK_STRETCH_EN  when defined, the phase-1 counter holds at 0 while synchronized SCL
//                       is low (slave clock stretching); otherwise scl_in is unused.
module i2c_bus_sequencer #(
  parameter int unsigned CLK_DIV = 250
) (
  input logic                  ref_clk,
  input logic                  reset,
  i2c_bus_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3, StDone} state_e;

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [9:0] CntLast  = 10'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic       bit_q, bit_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       ready_q;
  logic       rsp_valid_q;
  logic       rsp_bit_q, rsp_bit_d;
  logic       rsp_err_q, rsp_err_d;
  logic [1:0] sda_sync_q;
  logic       sda_s;
  logic       stretch_hold;
  logic [1:0] ph_q;

  // {scl_oe, sda_oe} for phase ph of command c; START keeps SCL as it was in phase 0.
  function automatic logic [1:0] phase_oe(input logic [1:0] c, input logic b,
                                          input logic [1:0] ph, input logic scl_hold);
    logic scl, sda;
    case (c)
      CmdStart: begin
        scl = (ph == 2'd0) ? scl_hold : (ph == 2'd3);
        sda = ph[1];
      end
      CmdStop: begin
        scl = (ph == 2'd0);
        sda = !ph[1];
      end
      CmdWrite: begin
        scl = (ph == 2'd0) || (ph == 2'd3);
        sda = !b;
      end
      default: begin
        scl = (ph == 2'd0) || (ph == 2'd3);
        sda = 1'b0;
      end
    endcase
    return {scl, sda};
  endfunction

  assign sda_s = sda_sync_q[1];

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync_q;
  logic       scl_s;

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) scl_sync_q <= 2'b11;
    else        scl_sync_q <= {scl_sync_q[0], bus.scl_in};
  end

  assign scl_s        = scl_sync_q[1];
  assign stretch_hold = (state_q == StP1) && !scl_s;
`else
  assign stretch_hold = 1'b0;
`endif

  always_comb begin
    unique case (state_q)
      StP1:    ph_q = 2'd1;
      StP2:    ph_q = 2'd2;
      StP3:    ph_q = 2'd3;
      default: ph_q = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    bit_d     = bit_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rsp_bit_d = rsp_bit_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          cmd_d     = bus.cmd;
          bit_d     = bus.cmd_bit;
          cnt_d     = '0;
          rsp_bit_d = 1'b0;
          // Data bits are only meaningful while we own the bus.
          if (bus.cmd[1] && !busy_q) begin
            rsp_err_d = 1'b1;
            state_d   = StDone;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = StP0;
            {scl_oe_d, sda_oe_d} = phase_oe(bus.cmd, bus.cmd_bit, 2'd0, scl_oe_q);
          end
        end
      end
      StP0, StP1, StP2, StP3: begin
        if (stretch_hold) begin
          cnt_d = '0;
        end else if (cnt_q != CntLast) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d = '0;
          if (state_q == StP1 && cmd_q[1]) rsp_bit_d = sda_s;
          if (state_q == StP3) begin
            state_d = StDone;
            if (cmd_q == CmdStart)     busy_d = 1'b1;
            else if (cmd_q == CmdStop) busy_d = 1'b0;
          end else begin
            state_d = (state_q == StP0) ? StP1 : (state_q == StP1) ? StP2 : StP3;
            {scl_oe_d, sda_oe_d} = phase_oe(cmd_q, bit_q, ph_q + 2'd1, scl_oe_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_q       <= CmdStart;
      bit_q       <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      sda_sync_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      bit_q       <= bit_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      ready_q     <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StDone);
      rsp_bit_q   <= rsp_bit_d;
      rsp_err_q   <= rsp_err_d;
      sda_sync_q  <= {sda_sync_q[0], bus.sda_in};
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

endmodule
